// File: rtl/line_buffer_mc.sv
// line_buffer_mc: multi-channel line buffer presenting BUF_DEPTH vertically
// aligned taps with frame-aware row-valid flags, measured line length and a
// sticky per-frame line-overflow flag. Two register stages on every output.

// One line memory: write port plus registered read (old data on collision).
module line_buffer_mc_mem #(
  parameter int W  = 24,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data
);
  logic [W-1:0] mem [2**AW];

  // storage write; contents survive reset
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  // registered read, sees pre-write contents when addresses collide
  always_ff @(posedge clk or negedge rst)
    if (!rst) rd_data <= '0;
    else      rd_data <= mem[rd_addr];
endmodule

module line_buffer_mc #(
  parameter int COLORDEPTH = 8,
  parameter int CHANNELS   = 3,
  parameter int MAXWIDTH   = 2048,
  parameter int BUF_DEPTH  = 3,
  parameter int ADDR_W     = $clog2(MAXWIDTH)
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [CHANNELS*COLORDEPTH-1:0]                   data_i,
  input  logic                                             dv_i,
  input  logic                                             hs_i,
  input  logic                                             vs_i,
  output logic                                             dv_o,
  output logic                                             hs_o,
  output logic                                             vs_o,
  output logic [BUF_DEPTH-1:0][CHANNELS*COLORDEPTH-1:0]    buff_o,
  output logic [BUF_DEPTH-1:0]                             row_valid_o,
  output logic [ADDR_W:0]                                  line_len_o,
  output logic                                             ovf_o
);
  localparam int PIX_W  = CHANNELS*COLORDEPTH;
  // vld_pipe[0] is the first register stage, vld_pipe[STAGES] drives dv_o
  localparam int STAGES = 1;
  localparam int RC_W   = $clog2(BUF_DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);
  localparam logic [RC_W-1:0] RC_MAX  = RC_W'(BUF_DEPTH-1);

  logic [STAGES:0] vld_pipe, hs_pipe, vs_pipe;

  // pixel count within the line; saturates at MAXWIDTH (top bit = line full)
  logic [ADDR_W:0]   cnt;
  logic              full;
  logic [ADDR_W-1:0] ptr;

  logic [PIX_W-1:0]  data_s1;
  logic [ADDR_W-1:0] ptr_s1;
  logic              wr_ok_s1;
  logic [RC_W-1:0]   row_cnt, rows_s1;
  logic              ovf_s1;
  logic [ADDR_W:0]   len_s1;
  logic              dv_rise, dv_fall, vs_rise;

  logic [BUF_DEPTH-1:0][PIX_W-1:0] tap_s1;

  assign full    = cnt[ADDR_W];
  assign ptr     = full ? '1 : cnt[ADDR_W-1:0];
  assign dv_rise = dv_i & ~vld_pipe[0];
  assign dv_fall = ~dv_i & vld_pipe[0];
  assign vs_rise = vs_i & ~vs_pipe[0];

  assign dv_o = vld_pipe[STAGES];
  assign hs_o = hs_pipe[STAGES];
  assign vs_o = vs_pipe[STAGES];

  assign tap_s1[0] = data_s1;

  // memory k holds the row k above; it is fed with tap k-1 of the same column
  for (genvar k = 1; k < BUF_DEPTH; k++) begin : g_mem
    line_buffer_mc_mem #(.W(PIX_W), .AW(ADDR_W)) u_mem (
      .clk     (clk),
      .rst     (rst),
      .rd_addr (ptr),
      .rd_data (tap_s1[k]),
      .wr_en   (wr_ok_s1),
      .wr_addr (ptr_s1),
      .wr_data (tap_s1[k-1])
    );
  end

  // sync delay lines for hs/vs
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hs_pipe <= '0;
      vs_pipe <= '0;
    end else begin
      hs_pipe <= {hs_pipe[STAGES-1:0], hs_i};
      vs_pipe <= {vs_pipe[STAGES-1:0], vs_i};
    end

  // first stage: column tracking, line/frame bookkeeping, pixel capture
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      vld_pipe <= '0;
      data_s1  <= '0;
      ptr_s1   <= '0;
      wr_ok_s1 <= 1'b0;
      cnt      <= '0;
      len_s1   <= '0;
      ovf_s1   <= 1'b0;
      row_cnt  <= '0;
      rows_s1  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], dv_i};
      data_s1  <= data_i;
      ptr_s1   <= ptr;
      // pixels past MAXWIDTH are passed through but never stored
      wr_ok_s1 <= dv_i & ~full;
      cnt      <= dv_i ? (full ? cnt : cnt + CNT_ONE) : '0;
      if (dv_fall) len_s1 <= cnt;
      ovf_s1   <= (ovf_s1 & ~vs_rise) | (dv_i & full);
      // frame start clears the row count even if a line ends that cycle
      if (vs_rise)                         row_cnt <= '0;
      else if (dv_fall && row_cnt != RC_MAX) row_cnt <= row_cnt + RC_ONE;
      // row count frozen at line start so the flags stay flat across the line
      if (dv_rise) rows_s1 <= vs_rise ? '0 : row_cnt;
    end

  // output stage: taps gated to zero when idle or when the column overflowed
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      buff_o      <= '0;
      row_valid_o <= '0;
      line_len_o  <= '0;
      ovf_o       <= 1'b0;
    end else begin
      buff_o[0]      <= vld_pipe[0] ? tap_s1[0] : '0;
      row_valid_o[0] <= vld_pipe[0];
      for (int k = 1; k < BUF_DEPTH; k++) begin
        buff_o[k]      <= (vld_pipe[0] && wr_ok_s1) ? tap_s1[k] : '0;
        row_valid_o[k] <= vld_pipe[0] && (rows_s1 >= RC_W'(k));
      end
      line_len_o <= len_s1;
      ovf_o      <= ovf_s1;
    end
endmodule

// File: tb/tb_line_buffer_mc.sv
// Bench for line_buffer_mc: directed and random frames checked against a
// line-history reference model with a two-cycle expected-value queue.
module tb_line_buffer_mc;
  localparam int CD = 8, CH = 3, MW = 16, BD = 3;
  localparam int AW = $clog2(MW);
  localparam int PW = CH*CD;

  logic clk = 1'b0;
  logic rst;
  logic [PW-1:0] data_i;
  logic dv_i, hs_i, vs_i;
  logic dv_o, hs_o, vs_o;
  logic [BD-1:0][PW-1:0] buff_o;
  logic [BD-1:0] row_valid_o;
  logic [AW:0] line_len_o;
  logic ovf_o;

  always #5 clk = ~clk;

  line_buffer_mc #(.COLORDEPTH(CD), .CHANNELS(CH), .MAXWIDTH(MW), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o), .buff_o(buff_o),
    .row_valid_o(row_valid_o), .line_len_o(line_len_o), .ovf_o(ovf_o)
  );

  typedef struct {
    logic dv, hs, vs;
    logic [BD-1:0][PW-1:0] buff;
    logic [BD-1:0] chk;
    logic [BD-1:0] rv;
    logic [AW:0] len;
    logic ovf;
  } exp_t;

  int n_tests = 0, n_fail = 0;
  exp_t q[$];

  // hist[j] = line j+1 rows above the line being received (this frame only
  // matters, gated by row count); lengths are stored lengths (<= MW)
  logic [PW-1:0] hist [BD-1][MW];
  int hist_len [BD-1];
  logic [PW-1:0] cur [MW];
  int cur_len, nrows, start_rows, m_len;
  logic m_ovf, m_dv_prev, m_vs_prev;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.dv = 0; e.hs = 0; e.vs = 0; e.buff = '0; e.chk = '1; e.rv = '0; e.len = '0; e.ovf = 0;
    return e;
  endfunction

  task automatic model_reset();
    cur_len = 0; nrows = 0; start_rows = 0; m_len = 0;
    m_ovf = 0; m_dv_prev = 0; m_vs_prev = 0;
    for (int j = 0; j < BD-1; j++) hist_len[j] = 0;
    q.delete();
    q.push_back(zero_exp());
    q.push_back(zero_exp());
  endtask

  task automatic compare(input exp_t e);
    chk("dv_o", dv_o, e.dv);
    chk("hs_o", hs_o, e.hs);
    chk("vs_o", vs_o, e.vs);
    chk("row_valid_o", row_valid_o, e.rv);
    chk("line_len_o", line_len_o, e.len);
    chk("ovf_o", ovf_o, e.ovf);
    for (int k = 0; k < BD; k++)
      if (e.chk[k]) chk($sformatf("buff_o[%0d]", k), buff_o[k], e.buff[k]);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " dv_o"}, dv_o, 0);
    chk({tag, " hs_o"}, hs_o, 0);
    chk({tag, " vs_o"}, vs_o, 0);
    chk({tag, " row_valid_o"}, row_valid_o, 0);
    chk({tag, " line_len_o"}, line_len_o, 0);
    chk({tag, " ovf_o"}, ovf_o, 0);
    for (int k = 0; k < BD; k++) chk($sformatf("%s buff_o[%0d]", tag, k), buff_o[k], 0);
  endtask

  // one input cycle: check outputs due now, drive inputs, queue their expectation
  task automatic step(input logic dv, input logic hs, input logic vs, input logic [PW-1:0] d);
    exp_t e;
    logic vs_rise;
    int col;
    @(negedge clk);
    compare(q.pop_front());
    dv_i = dv; hs_i = hs; vs_i = vs; data_i = d;
    e = zero_exp();
    vs_rise = vs && !m_vs_prev;
    if (vs_rise) begin m_ovf = 0; nrows = 0; end
    if (!dv && m_dv_prev) begin
      m_len = (cur_len > MW) ? MW : cur_len;
      for (int j = BD-2; j > 0; j--) begin
        for (int c = 0; c < MW; c++) hist[j][c] = hist[j-1][c];
        hist_len[j] = hist_len[j-1];
      end
      for (int c = 0; c < MW; c++) hist[0][c] = cur[c];
      hist_len[0] = m_len;
      if (!vs_rise && nrows < BD-1) nrows++;
    end
    if (dv) begin
      if (!m_dv_prev) begin start_rows = nrows; cur_len = 0; end
      col = cur_len;
      cur_len++;
      e.dv = 1; e.buff[0] = d; e.rv[0] = 1;
      if (col >= MW) m_ovf = 1;
      else cur[col] = d;
      for (int k = 1; k < BD; k++) begin
        e.rv[k] = (start_rows >= k);
        if (col >= MW) begin
          e.buff[k] = '0; e.chk[k] = 1;
        end else begin
          e.chk[k] = e.rv[k];
          for (int j = 0; j < k; j++) if (hist_len[j] <= col) e.chk[k] = 0;
          e.buff[k] = hist[k-1][col];
        end
      end
    end
    e.hs = hs; e.vs = vs; e.len = (AW+1)'(m_len); e.ovf = m_ovf;
    m_dv_prev = dv; m_vs_prev = vs;
    q.push_back(e);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    compare(q.pop_front());
    rst = 0; dv_i = 0; hs_i = 0; vs_i = 0; data_i = '0;
    #1;
    check_all_zero("midline reset");
    @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  task automatic run_line(input int len, input int row, input int pat, input int gap, input int rst_col);
    logic [PW-1:0] d;
    for (int c = 0; c < len; c++) begin
      if (c == rst_col) begin pulse_reset(); return; end
      case (pat)
        0:       d = PW'(row*16 + c);
        1:       d = {8'hAA, 8'(row), 8'(c)};
        default: d = PW'($urandom);
      endcase
      step(1, 0, 0, d);
    end
    for (int g = 0; g < gap; g++) step(0, 1, 0, '0);
  endtask

  task automatic vsync();
    for (int i = 0; i < 3; i++) step(0, 0, 1, '0);
    step(0, 0, 0, '0);
  endtask

  initial begin
    int nl;
    rst = 0; dv_i = 0; hs_i = 0; vs_i = 0; data_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset state");
    @(negedge clk);
    rst = 1;
    model_reset();

    // 4 x 8 frame, data = row*16+col; last line ends as vs rises
    vsync();
    for (int r = 0; r < 4; r++) run_line(8, r, 0, (r == 3) ? 0 : 2, -1);
    // back-to-back frame with per-channel patterns over stale memory
    vsync();
    for (int r = 0; r < 4; r++) run_line(8, r, 1, 2, -1);
    // overflowing lines
    vsync();
    run_line(20, 0, 0, 2, -1);
    run_line(20, 1, 0, 2, -1);
    run_line(8, 2, 0, 2, -1);
    // varying line lengths
    vsync();
    run_line(8, 0, 2, 2, -1);
    run_line(6, 1, 2, 2, -1);
    run_line(8, 2, 2, 2, -1);
    // reset in the middle of line 2
    vsync();
    run_line(8, 0, 0, 2, -1);
    run_line(8, 1, 0, 2, -1);
    run_line(8, 2, 0, 0, 4);
    run_line(8, 3, 0, 2, -1);
    run_line(8, 4, 0, 2, -1);
    // random frames
    for (int f = 0; f < 4; f++) begin
      vsync();
      nl = $urandom_range(5, 2);
      for (int r = 0; r < nl; r++)
        run_line($urandom_range(20, 1), r, 2, $urandom_range(3, (r == nl-1) ? 0 : 1), -1);
    end
    repeat (3) step(0, 0, 0, '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
